// File: rtl/tracking_loop_arbiter_pkg.sv
// tracking_loop_arbiter_pkg: shared FSM encoding, defaults and wait-counter sizing for the tracking-loop arbiter
package tracking_loop_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_TIMEOUT = 255;
  function automatic int cnt_width(input int timeout);
    return ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;
  endfunction
  localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate, find-first-set, un-rotate round-robin picker
module rr_priority_pick #(
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [SEL_W-1:0] rr,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);
  logic [N-1:0]     w_rot;
  logic [SEL_W-1:0] w_off;
  logic [SEL_W:0]   w_sum;
  always_comb begin
    w_rot = N'({pending, pending} >> rr);
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) w_off = w_rot[i] ? SEL_W'(i) : w_off;
    w_sum = {1'b0, rr} + {1'b0, w_off};
    grant_idx = (w_sum >= (SEL_W + 1)'(N)) ? SEL_W'(w_sum - (SEL_W + 1)'(N)) : w_sum[SEL_W-1:0];
  end
  assign any = |pending;
endmodule

// File: rtl/tracking_loop_arbiter.sv
// tracking_loop_arbiter: round-robin scheduler sharing one tracking_loops engine among correlator channels
module tracking_loop_arbiter import tracking_loop_arbiter_pkg::*; #(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SEL_W = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CHANNELS-1:0] req_valid,
  input  logic                    loop_done,
  output logic [SEL_W-1:0]        loop_sel,
  output logic                    loop_start,
  output logic [NUM_CHANNELS-1:0] chan_ready,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] overrun,
  output logic                    timeout_err
);
  localparam int CW = cnt_width(TIMEOUT);
  state_t                  r_state, w_next;
  logic [NUM_CHANNELS-1:0] r_pending, r_overrun, w_clr, w_sel_oh;
  logic [SEL_W-1:0]        r_sel, r_rr, w_grant, w_rr_next;
  logic [CW-1:0]           r_cnt;
  logic                    w_any, w_hit, w_timeout, w_served, r_timeout;
  rr_priority_pick #(.N(NUM_CHANNELS), .SEL_W(SEL_W)) u_pick (
    .pending(r_pending),
    .rr(r_rr),
    .grant_idx(w_grant),
    .any(w_any)
  );
  always_comb begin
    w_sel_oh = NUM_CHANNELS'(1) << r_sel;
    w_hit = ({1'b0, r_cnt} + 1'b1) == (CW + 1)'(TIMEOUT);
    w_timeout = (r_state == S_WAIT) && !loop_done && w_hit;
    w_served = (r_state == S_DONE) || w_timeout;
    w_clr = w_served ? w_sel_oh : '0;
    w_rr_next = (r_sel == SEL_W'(NUM_CHANNELS - 1)) ? '0 : r_sel + 1'b1;
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_START : S_IDLE;
      S_START: w_next = S_WAIT;
      S_WAIT:  w_next = loop_done ? S_DONE : (w_hit ? S_IDLE : S_WAIT);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_overrun <= '0;
      r_sel     <= '0;
      r_rr      <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pending <= (r_pending & ~w_clr) | req_valid;
      r_overrun <= r_overrun | (r_pending & req_valid);
      r_timeout <= w_timeout;
      r_sel     <= (r_state == S_IDLE && w_any) ? w_grant : r_sel;
      r_rr      <= w_served ? w_rr_next : r_rr;
      r_cnt     <= (r_state == S_START) ? '0 : (r_state == S_WAIT && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign loop_sel    = r_sel;
  assign loop_start  = r_state == S_START;
  assign busy        = (r_state == S_START) || (r_state == S_WAIT);
  assign chan_ready  = (r_state == S_DONE) ? w_sel_oh : '0;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;
endmodule
